gon_burst_collector: RTL and testbench

GON_BURST_COLLECTOR -- requirements
Module: gon_burst_collector

---
 rtl/gon_burst_collector.sv | 247 ++++++++++++++++++++++++
 tb/tb_gon_burst_collector.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gon_burst_collector.sv
// gon_burst_collector
//   Gathers bursts of words from a NUM_OF_ROWS x NUM_OF_COLS array of PEs.
//   A tag FIFO queues {burst_len, col_tag, row_tag} requests. A three-state
//   FSM (IDLE/LOAD/XFER) pops one tag at a time, validates it, then pops
//   burst_len words from the addressed PE into a first-word-fall-through
//   data FIFO.
//
// Ports
//   clk          single clock
//   reset        synchronous, active-low reset
//   tags_wr_en   push {burst_len, col_tag, row_tag} into the tag FIFO
//   row_tag      target PE row
//   col_tag      target PE column
//   burst_len    number of words to gather
//   tags_full    tag FIFO full (pushes are dropped)
//   ready_in     per-PE word-valid, index r*NUM_OF_COLS+c
//   data_in      flattened PE words, same indexing
//   enable_out   one-hot pop strobe to the addressed PE
//   data_rd_en   pop the head of the data FIFO
//   data_out     head of the data FIFO, valid while data_empty==0
//   data_empty   data FIFO empty
//   data_count   data FIFO occupancy
//   busy         FSM is in LOAD or XFER
//   err_tag      sticky: a tag addressed a PE outside the array
//   beat_count   words transferred (saturating)
//   stall_count  XFER cycles without a transfer (saturating)
//
// Configuration
//   GON_BURST_PERF_CNT_EN  when defined, beat_count/stall_count are live
//                          saturating counters; otherwise both are tied to 0.
module gon_burst_collector #(
  parameter int DATA_WIDTH      = 64,
  parameter int NUM_OF_ROWS     = 12,
  parameter int NUM_OF_COLS     = 14,
  parameter int ROW_TAG_WIDTH   = 4,
  parameter int COL_TAG_WIDTH   = 4,
  parameter int BURST_WIDTH     = 8,
  parameter int TAGS_FIFO_DEPTH = 16,
  parameter int DATA_FIFO_DEPTH = 16
) (
  input  logic                                        clk,
  input  logic                                        reset,
  input  logic                                        tags_wr_en,
  input  logic [ROW_TAG_WIDTH-1:0]                    row_tag,
  input  logic [COL_TAG_WIDTH-1:0]                    col_tag,
  input  logic [BURST_WIDTH-1:0]                      burst_len,
  output logic                                        tags_full,
  input  logic [NUM_OF_ROWS*NUM_OF_COLS-1:0]          ready_in,
  input  logic [NUM_OF_ROWS*NUM_OF_COLS*DATA_WIDTH-1:0] data_in,
  output logic [NUM_OF_ROWS*NUM_OF_COLS-1:0]          enable_out,
  input  logic                                        data_rd_en,
  output logic [DATA_WIDTH-1:0]                       data_out,
  output logic                                        data_empty,
  output logic [$clog2(DATA_FIFO_DEPTH):0]            data_count,
  output logic                                        busy,
  output logic                                        err_tag,
  output logic [31:0]                                 beat_count,
  output logic [31:0]                                 stall_count
);

  localparam int NUM_PE = NUM_OF_ROWS * NUM_OF_COLS;
  localparam int SEL_W  = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
  localparam int TAG_W  = BURST_WIDTH + COL_TAG_WIDTH + ROW_TAG_WIDTH;
  localparam int TA_W   = $clog2(TAGS_FIFO_DEPTH);
  localparam int DA_W   = $clog2(DATA_FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, XFER} state_t;

  state_t                   state_q, state_d;
  logic [ROW_TAG_WIDTH-1:0] cur_row_q, cur_row_d;
  logic [COL_TAG_WIDTH-1:0] cur_col_q, cur_col_d;
  logic [BURST_WIDTH-1:0]   remaining_q, remaining_d;
  logic                     err_tag_q, err_tag_d;

  // ---------------------------------------------------------------- tag FIFO
  logic [TAG_W-1:0]         tag_mem_q [TAGS_FIFO_DEPTH];
  logic [TA_W:0]            tag_wr_ptr_q, tag_rd_ptr_q;
  logic                     tags_empty, tag_push, tag_pop;
  logic [TAG_W-1:0]         tag_head;
  logic [ROW_TAG_WIDTH-1:0] head_row;
  logic [COL_TAG_WIDTH-1:0] head_col;
  logic [BURST_WIDTH-1:0]   head_len;

  // The extra pointer MSB distinguishes full (MSBs differ) from empty.
  assign tags_empty = (tag_wr_ptr_q == tag_rd_ptr_q);
  assign tags_full  = (tag_wr_ptr_q[TA_W] != tag_rd_ptr_q[TA_W]) &&
                      (tag_wr_ptr_q[TA_W-1:0] == tag_rd_ptr_q[TA_W-1:0]);
  assign tag_push   = tags_wr_en && !tags_full;
  assign tag_head   = tag_mem_q[tag_rd_ptr_q[TA_W-1:0]];
  assign head_row   = tag_head[ROW_TAG_WIDTH-1:0];
  assign head_col   = tag_head[ROW_TAG_WIDTH +: COL_TAG_WIDTH];
  assign head_len   = tag_head[ROW_TAG_WIDTH+COL_TAG_WIDTH +: BURST_WIDTH];

  always_ff @(posedge clk) begin
    if (tag_push) tag_mem_q[tag_wr_ptr_q[TA_W-1:0]] <= {burst_len, col_tag, row_tag};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      tag_wr_ptr_q <= '0;
      tag_rd_ptr_q <= '0;
    end else begin
      if (tag_push) tag_wr_ptr_q <= tag_wr_ptr_q + 1'b1;
      if (tag_pop)  tag_rd_ptr_q <= tag_rd_ptr_q + 1'b1;
    end
  end

  // --------------------------------------------------------------- PE select
  logic [SEL_W-1:0]      sel;
  logic                  tag_in_range;
  logic [DATA_WIDTH-1:0] pe_word [NUM_PE];

  assign sel          = SEL_W'(32'(cur_row_q) * 32'(NUM_OF_COLS) + 32'(cur_col_q));
  assign tag_in_range = (32'(cur_row_q) < 32'(NUM_OF_ROWS)) &&
                        (32'(cur_col_q) < 32'(NUM_OF_COLS));

  for (genvar g = 0; g < NUM_PE; g++) begin : g_pe_word
    assign pe_word[g] = data_in[g*DATA_WIDTH +: DATA_WIDTH];
  end

  // --------------------------------------------------------------- data FIFO
  logic [DATA_WIDTH-1:0] data_mem_q [DATA_FIFO_DEPTH];
  logic [DA_W:0]         data_wr_ptr_q, data_rd_ptr_q;
  logic                  data_full, data_pop, beat;

  assign data_empty = (data_wr_ptr_q == data_rd_ptr_q);
  assign data_full  = (data_wr_ptr_q[DA_W] != data_rd_ptr_q[DA_W]) &&
                      (data_wr_ptr_q[DA_W-1:0] == data_rd_ptr_q[DA_W-1:0]);
  assign data_pop   = data_rd_en && !data_empty;
  assign data_out   = data_mem_q[data_rd_ptr_q[DA_W-1:0]];
  assign data_count = data_wr_ptr_q - data_rd_ptr_q;

  // A beat needs the PE to offer a word and room in the data FIFO; the
  // tag was range-checked in LOAD, so sel is always a real PE here.
  assign beat = (state_q == XFER) && ready_in[sel] && !data_full;

  always_comb begin
    enable_out = '0;
    if (beat) enable_out[sel] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (beat) data_mem_q[data_wr_ptr_q[DA_W-1:0]] <= pe_word[sel];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      data_wr_ptr_q <= '0;
      data_rd_ptr_q <= '0;
    end else begin
      if (beat)     data_wr_ptr_q <= data_wr_ptr_q + 1'b1;
      if (data_pop) data_rd_ptr_q <= data_rd_ptr_q + 1'b1;
    end
  end

  // --------------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      cur_row_q   <= '0;
      cur_col_q   <= '0;
      remaining_q <= '0;
      err_tag_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_row_q   <= cur_row_d;
      cur_col_q   <= cur_col_d;
      remaining_q <= remaining_d;
      err_tag_q   <= err_tag_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cur_row_d   = cur_row_q;
    cur_col_d   = cur_col_q;
    remaining_d = remaining_q;
    err_tag_d   = err_tag_q;
    tag_pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!tags_empty) begin
          tag_pop     = 1'b1;
          cur_row_d   = head_row;
          cur_col_d   = head_col;
          remaining_d = head_len;
          state_d     = LOAD;
        end
      end
      LOAD: begin
        if (!tag_in_range) begin
          err_tag_d = 1'b1;
          state_d   = IDLE;
        end else if (remaining_q == '0) begin
          state_d = IDLE;
        end else begin
          state_d = XFER;
        end
      end
      XFER: begin
        if (beat) begin
          remaining_d = remaining_q - 1'b1;
          // Last beat: chain straight into the next tag so back-to-back
          // bursts do not pay an extra IDLE cycle.
          if (remaining_q == BURST_WIDTH'(1)) begin
            if (!tags_empty) begin
              tag_pop     = 1'b1;
              cur_row_d   = head_row;
              cur_col_d   = head_col;
              remaining_d = head_len;
              state_d     = LOAD;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy    = (state_q != IDLE);
  assign err_tag = err_tag_q;

  // ----------------------------------------------------- performance counters
`ifdef GON_BURST_PERF_CNT_EN
  logic [31:0] beat_cnt_q, stall_cnt_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      beat_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (beat && (beat_cnt_q != '1)) beat_cnt_q <= beat_cnt_q + 1'b1;
      if ((state_q == XFER) && !beat && (stall_cnt_q != '1))
        stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign beat_count  = beat_cnt_q;
  assign stall_count = stall_cnt_q;
`else
  assign beat_count  = '0;
  assign stall_count = '0;
`endif

endmodule

// File: tb/tb_gon_burst_collector.sv
// Bench for gon_burst_collector (12x14 PEs, 32-bit words, 4-deep data FIFO,
// 16-deep tag FIFO). A queue-based reference model is stepped every clock
// and compared against the DUT every cycle; directed scenarios add literal
// expectations, followed by a randomized run.
module tb_gon_burst_collector;

  localparam int R   = 12;
  localparam int C   = 14;
  localparam int NPE = R * C;
  localparam int DW  = 32;
  localparam int DD  = 4;
  localparam int TD  = 16;
`ifdef GON_BURST_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  localparam int M_IDLE = 0;
  localparam int M_LOAD = 1;
  localparam int M_XFER = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic              tags_wr_en;
  logic [3:0]        row_tag;
  logic [3:0]        col_tag;
  logic [7:0]        burst_len;
  logic              tags_full;
  logic [NPE-1:0]    ready_in;
  logic [NPE*DW-1:0] data_in;
  logic [NPE-1:0]    enable_out;
  logic              data_rd_en;
  logic [DW-1:0]     data_out;
  logic              data_empty;
  logic [2:0]        data_count;
  logic              busy;
  logic              err_tag;
  logic [31:0]       beat_count;
  logic [31:0]       stall_count;

  gon_burst_collector #(
    .DATA_WIDTH(DW), .NUM_OF_ROWS(R), .NUM_OF_COLS(C),
    .ROW_TAG_WIDTH(4), .COL_TAG_WIDTH(4), .BURST_WIDTH(8),
    .TAGS_FIFO_DEPTH(TD), .DATA_FIFO_DEPTH(DD)
  ) dut (
    .clk(clk), .reset(reset), .tags_wr_en(tags_wr_en), .row_tag(row_tag),
    .col_tag(col_tag), .burst_len(burst_len), .tags_full(tags_full),
    .ready_in(ready_in), .data_in(data_in), .enable_out(enable_out),
    .data_rd_en(data_rd_en), .data_out(data_out), .data_empty(data_empty),
    .data_count(data_count), .busy(busy), .err_tag(err_tag),
    .beat_count(beat_count), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] len;
    logic [3:0] col;
    logic [3:0] row;
  } tag_t;

  // Reference model
  tag_t        tq[$];
  logic [31:0] dq[$];
  int          m_phase = M_IDLE;
  int          m_row = 0, m_col = 0, m_rem = 0;
  bit          m_err = 1'b0;
  longint      m_beats = 0, m_stalls = 0;
  int          pe_seq [NPE];
  int          pe_pop = -1;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic logic [31:0] sat32(input longint v);
    return (v > 64'sh0FFFFFFFF) ? 32'hFFFF_FFFF : 32'(v);
  endfunction

  task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic void take();
    tag_t h;
    h = tq.pop_front();
    m_row = int'(h.row);
    m_col = int'(h.col);
    m_rem = int'(h.len);
  endfunction

  // Advances the model by one clock using the inputs present before the edge.
  task automatic model_update();
    bit beat, had_tag, push_ok;
    int idx;
    pe_pop = -1;
    if (!reset) begin
      tq.delete(); dq.delete();
      m_phase = M_IDLE; m_row = 0; m_col = 0; m_rem = 0;
      m_err = 1'b0; m_beats = 0; m_stalls = 0;
      return;
    end
    idx     = m_row * C + m_col;
    beat    = (m_phase == M_XFER) && ready_in[idx] && (dq.size() < DD);
    had_tag = (tq.size() > 0);
    push_ok = (tq.size() < TD);
    if (data_rd_en && dq.size() > 0) void'(dq.pop_front());
    if (beat) begin
      dq.push_back(data_in[idx*DW +: DW]);
      pe_pop = idx;
    end
    case (m_phase)
      M_IDLE: if (had_tag) begin take(); m_phase = M_LOAD; end
      M_LOAD: begin
        if (m_row >= R || m_col >= C) begin m_err = 1'b1; m_phase = M_IDLE; end
        else if (m_rem == 0) m_phase = M_IDLE;
        else m_phase = M_XFER;
      end
      default: begin
        if (beat) begin
          m_beats++;
          m_rem--;
          if (m_rem == 0) begin
            if (had_tag) begin take(); m_phase = M_LOAD; end
            else m_phase = M_IDLE;
          end
        end else begin
          m_stalls++;
        end
      end
    endcase
    if (tags_wr_en && push_ok) tq.push_back({burst_len, col_tag, row_tag});
  endtask

  task automatic compare_all();
    logic [NPE-1:0] exp_en;
    int idx;
    exp_en = '0;
    idx = m_row * C + m_col;
    if (m_phase == M_XFER && ready_in[idx] && dq.size() < DD) exp_en[idx] = 1'b1;
    chk("enable_out", enable_out, exp_en);
    chk("busy", busy, m_phase != M_IDLE);
    chk("tags_full", tags_full, tq.size() == TD);
    chk("data_empty", data_empty, dq.size() == 0);
    chk("data_count", data_count, dq.size());
    if (dq.size() > 0) chk("data_out", data_out, dq[0]);
    chk("err_tag", err_tag, m_err);
    chk("beat_count", beat_count, PERF ? sat32(m_beats) : 32'd0);
    chk("stall_count", stall_count, PERF ? sat32(m_stalls) : 32'd0);
  endtask

  task automatic step(input bit cmp = 1'b1);
    @(negedge clk);
    if (cmp) compare_all();
    @(posedge clk);
    model_update();
    #1;
    if (pe_pop >= 0) begin
      pe_seq[pe_pop]++;
      data_in[pe_pop*DW +: DW] = {8'(pe_pop), 24'(pe_seq[pe_pop])};
    end
  endtask

  task automatic set_tag(input int r, input int c, input int l);
    row_tag    = 4'(r);
    col_tag    = 4'(c);
    burst_len  = 8'(l);
    tags_wr_en = 1'b1;
  endtask

  task automatic do_reset();
    reset = 1'b0; tags_wr_en = 1'b0; data_rd_en = 1'b0;
    step();
    reset = 1'b1;
  endtask

  initial begin
    int first, last, cnt, saw, cnt2;
    bit consec, busy_ok;
    reset = 1'b0; tags_wr_en = 1'b0; row_tag = '0; col_tag = '0; burst_len = '0;
    ready_in = '0; data_rd_en = 1'b0;
    for (int k = 0; k < NPE; k++) begin
      pe_seq[k] = 0;
      data_in[k*DW +: DW] = {8'(k), 24'd0};
    end
    @(posedge clk); #1;
    step(1'b0);
    reset = 1'b1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_tags_full", tags_full, 1'b0);
    chk("rst_data_empty", data_empty, 1'b1);
    chk("rst_data_count", data_count, 3'd0);
    chk("rst_enable_out", enable_out, '0);
    chk("rst_err_tag", err_tag, 1'b0);
    chk("rst_beat_count", beat_count, 32'd0);

    // Single burst r=2 c=5 len=3 -> PE 33, beats on cycles 3,4,5
    ready_in = '0; ready_in[33] = 1'b1;
    set_tag(2, 5, 3); step(); tags_wr_en = 1'b0;
    first = -1; last = -1; cnt = 0; consec = 1'b1;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      if (enable_out[33]) begin
        if (first < 0) first = cyc; else if (cyc != last + 1) consec = 1'b0;
        last = cyc; cnt++;
      end
      step();
    end
    chk("burst_first_cycle", first, 3);
    chk("burst_beats", cnt, 3);
    chk("burst_consecutive", consec, 1'b1);
    chk("burst_busy_drop", busy, 1'b0);
    chk("burst_count", data_count, 3'd3);
    data_rd_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("burst_word", data_out, 32'h2100_0000 + 32'(i));
      step();
    end
    data_rd_en = 1'b0;

    // Out-of-range row, then a valid tag
    do_reset();
    ready_in = '0; ready_in[1] = 1'b1;
    set_tag(12, 0, 4); step(); tags_wr_en = 1'b0;
    saw = 0;
    for (int cyc = 1; cyc <= 6; cyc++) begin
      if (enable_out != '0) saw = 1;
      step();
    end
    chk("badtag_err", err_tag, 1'b1);
    chk("badtag_busy", busy, 1'b0);
    chk("badtag_no_enable", saw, 0);
    set_tag(0, 1, 1); step(); tags_wr_en = 1'b0;
    cnt = 0;
    for (int cyc = 1; cyc <= 6; cyc++) begin
      if (enable_out[1]) cnt++;
      step();
    end
    chk("badtag_next_beats", cnt, 1);
    chk("badtag_err_sticky", err_tag, 1'b1);
    chk("badtag_next_count", data_count, 3'd1);

    // Data FIFO back-pressure: len=6 into a 4-deep FIFO
    do_reset();
    ready_in = '0; ready_in[2] = 1'b1;
    set_tag(0, 2, 6); step(); tags_wr_en = 1'b0;
    cnt = 0;
    for (int cyc = 1; cyc <= 14; cyc++) begin
      if (enable_out[2]) cnt++;
      step();
    end
    chk("bp_beats_full", cnt, 4);
    chk("bp_busy_held", busy, 1'b1);
    chk("bp_count_full", data_count, 3'd4);
    data_rd_en = 1'b1;
    for (int cyc = 0; cyc < 2; cyc++) begin
      if (enable_out[2]) cnt++;
      step();
    end
    data_rd_en = 1'b0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      if (enable_out[2]) cnt++;
      step();
    end
    chk("bp_beats_total", cnt, 6);
    chk("bp_busy_done", busy, 1'b0);
    chk("bp_count_end", data_count, 3'd4);

    // Back-to-back len=1 tags: second LOAD directly after first beat
    do_reset();
    ready_in = '0; ready_in[3] = 1'b1; ready_in[4] = 1'b1;
    set_tag(0, 3, 1); step();
    first = -1; last = -1; busy_ok = 1'b1;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      if (cyc == 1) set_tag(0, 4, 1); else tags_wr_en = 1'b0;
      if (enable_out[3]) first = cyc;
      if (enable_out[4]) last = cyc;
      if (cyc >= 2 && cyc <= 5 && !busy) busy_ok = 1'b0;
      step();
    end
    chk("b2b_first_beat", first, 3);
    chk("b2b_second_beat", last, 5);
    chk("b2b_no_idle", busy_ok, 1'b1);

    // Reset during the second beat of len=5
    do_reset();
    ready_in = '0; ready_in[14] = 1'b1;
    set_tag(1, 0, 5); step();
    for (int cyc = 1; cyc <= 4; cyc++) begin
      if (cyc == 1) set_tag(1, 0, 2); else tags_wr_en = 1'b0;
      if (cyc == 4) begin
        chk("rstmid_beat2", enable_out[14], 1'b1);
        reset = 1'b0;
      end
      step();
    end
    reset = 1'b1;
    chk("rstmid_enable", enable_out, '0);
    chk("rstmid_empty", data_empty, 1'b1);
    chk("rstmid_busy", busy, 1'b0);
    chk("rstmid_tags_full", tags_full, 1'b0);
    saw = 0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      if (busy) saw = 1;
      step();
    end
    chk("rstmid_tags_dropped", saw, 0);

    // Tag FIFO overflow while the FSM is stalled on PE 0
    do_reset();
    ready_in = '0;
    set_tag(0, 0, 1); step(); tags_wr_en = 1'b0;
    step(); step();
    chk("ovf_stalled_busy", busy, 1'b1);
    for (int k = 0; k < 17; k++) begin
      if (k == 16) chk("ovf_full_at_16", tags_full, 1'b1);
      set_tag(0, 1, 1);
      step();
    end
    tags_wr_en = 1'b0;
    chk("ovf_full_after", tags_full, 1'b1);
    ready_in[0] = 1'b1; ready_in[1] = 1'b1; data_rd_en = 1'b1;
    cnt2 = 0;
    for (int cyc = 0; cyc < 120; cyc++) begin
      if (enable_out[1]) cnt2++;
      step();
    end
    chk("ovf_serviced", cnt2, 16);
    chk("ovf_idle", busy, 1'b0);
    chk("ovf_not_full", tags_full, 1'b0);

    // Randomized traffic
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      tags_wr_en = ($urandom_range(0, 3) == 0);
      row_tag    = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(12, 15)) : 4'($urandom_range(0, 11));
      col_tag    = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(14, 15)) : 4'($urandom_range(0, 13));
      burst_len  = 8'($urandom_range(0, 6));
      for (int k = 0; k < NPE; k++) ready_in[k] = ($urandom_range(0, 3) != 0);
      data_rd_en = ($urandom_range(0, 2) != 0);
      reset      = ($urandom_range(0, 599) != 0);
      step();
    end
    reset = 1'b1; tags_wr_en = 1'b0; ready_in = '1; data_rd_en = 1'b1;
    for (int n = 0; n < 300; n++) step();
    chk("drain_idle", busy, 1'b0);
    chk("drain_empty", data_empty, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
